// File: rtl/bl_link_pkg.sv
// Shared definitions for the BL_MUX address/enable link: address width,
// channel count, receive-side state encoding and the one-hot decoder.
package bl_link_pkg;

  localparam int BL_ADDR_W = 3;
  localparam int BL_NUM_CH = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_QUALIFY = 2'd1;
  localparam logic [1:0] ST_ASSERT  = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_QUALIFY = ST_QUALIFY,
    S_ASSERT  = ST_ASSERT,
    S_RELEASE = ST_RELEASE
  } bl_state_t;

  function automatic logic [BL_NUM_CH-1:0] bl_decode(input logic [BL_ADDR_W-1:0] addr);
    bl_decode       = '0;
    bl_decode[addr] = 1'b1;
  endfunction

endpackage

// File: rtl/bl_stable_filter.sv
// Registers the raw link inputs and counts consecutive matching samples of
// the candidate address; raises qualified once the count reaches STABLE_CYCLES.
module bl_stable_filter
  import bl_link_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 en,
  input  logic [BL_ADDR_W-1:0] addr,
  output logic                 r_en,
  output logic [BL_ADDR_W-1:0] cand,
  output logic                 qualified
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [BL_ADDR_W-1:0] r_addr;
  logic [CW-1:0]        cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en   <= 1'b0;
      r_addr <= '0;
      cand   <= '0;
      cnt    <= '0;
    end else begin
      r_en   <= en;
      r_addr <= addr;
      // Counting only runs while the FSM is looking for a new decode.
      if (!enable || !r_en) begin
        cnt <= '0;
      end else if (cnt == '0 || r_addr != cand) begin
        cand <= r_addr;
        cnt  <= CW'(1);
      end else if (cnt != CW'(STABLE_CYCLES)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign qualified = enable && r_en && (r_addr == cand) && (cnt == CW'(STABLE_CYCLES));

endmodule

// File: rtl/bl_demux_rx.sv
// Receive end of the BL_MUX link: qualifies a stable address, presents a
// one-hot channel enable until acknowledged, and flags ack timeouts.
module bl_demux_rx
  import bl_link_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 EN_in,
  input  logic                 A2_in,
  input  logic                 A1_in,
  input  logic                 A0_in,
  input  logic                 Ack_in,
  output logic [BL_NUM_CH-1:0] Y_out,
  output logic [BL_ADDR_W-1:0] Addr_out,
  output logic                 Valid_out,
  output logic                 Err_out
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  bl_state_t            state;
  logic [TW-1:0]        tmo;
  logic                 r_en;
  logic                 qualified;
  logic                 filt_enable;
  logic [BL_ADDR_W-1:0] cand;

  assign filt_enable = (state == S_IDLE) || (state == S_QUALIFY);

  bl_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk      (clk),
    .rst      (Reset),
    .enable   (filt_enable),
    .en       (EN_in),
    .addr     ({A2_in, A1_in, A0_in}),
    .r_en     (r_en),
    .cand     (cand),
    .qualified(qualified)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      tmo       <= '0;
      Y_out     <= '0;
      Addr_out  <= '0;
      Valid_out <= 1'b0;
      Err_out   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (r_en) state <= S_QUALIFY;
        end
        S_QUALIFY: begin
          if (!r_en) begin
            state <= S_IDLE;
          end else if (qualified) begin
            state     <= S_ASSERT;
            Y_out     <= bl_decode(cand);
            Addr_out  <= cand;
            Valid_out <= 1'b1;
            tmo       <= '0;
          end
        end
        S_ASSERT: begin
          // Ack takes priority over a simultaneous enable drop.
          if (Ack_in) begin
            state     <= S_RELEASE;
            Y_out     <= '0;
            Addr_out  <= '0;
            Valid_out <= 1'b0;
          end else if (!r_en) begin
            state     <= S_IDLE;
            Y_out     <= '0;
            Addr_out  <= '0;
            Valid_out <= 1'b0;
          end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            state     <= S_RELEASE;
            Err_out   <= 1'b1;
            Y_out     <= '0;
            Addr_out  <= '0;
            Valid_out <= 1'b0;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        S_RELEASE: begin
          if (!r_en) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bl_demux_rx.sv
// Bench for bl_demux_rx: directed scenarios plus random traffic, all
// compared cycle by cycle against a run-length based reference model.
module tb_bl_demux_rx;

  localparam int STABLE_CYCLES  = 4;
  localparam int TIMEOUT_CYCLES = 255;

  localparam logic [1:0] M_WAIT = 2'd0;
  localparam logic [1:0] M_HELD = 2'd1;
  localparam logic [1:0] M_DONE = 2'd2;

  logic       clk = 1'b0;
  logic       Reset;
  logic       EN_in, A2_in, A1_in, A0_in, Ack_in;
  logic [7:0] Y_out;
  logic [2:0] Addr_out;
  logic       Valid_out, Err_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bl_demux_rx #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk      (clk),
    .Reset    (Reset),
    .EN_in    (EN_in),
    .A2_in    (A2_in),
    .A1_in    (A1_in),
    .A0_in    (A0_in),
    .Ack_in   (Ack_in),
    .Y_out    (Y_out),
    .Addr_out (Addr_out),
    .Valid_out(Valid_out),
    .Err_out  (Err_out)
  );

  // Reference: a decode fires once STABLE_CYCLES+1 consecutive registered
  // samples carry EN=1 and the same address; it is then held for at most
  // TIMEOUT_CYCLES cycles waiting for an ack.
  typedef struct packed {
    logic       pen;
    logic [2:0] paddr;
    logic [1:0] mode;
    logic [2:0] last;
    logic       err;
    logic       valid;
    logic [2:0] addr;
    int         run;
    int         age;
  } model_t;

  model_t m;

  function automatic model_t step(model_t c, logic rst, logic en, logic [2:0] a, logic ack);
    model_t n;
    n = c;
    if (rst) return '0;
    n.pen   = en;
    n.paddr = a;
    case (c.mode)
      M_WAIT: begin
        if (!c.pen) n.run = 0;
        else if (c.run > 0 && c.paddr == c.last) n.run = c.run + 1;
        else n.run = 1;
        n.last = c.paddr;
        if (n.run == STABLE_CYCLES + 1) begin
          n.mode  = M_HELD;
          n.valid = 1'b1;
          n.addr  = c.paddr;
          n.age   = 0;
        end
      end
      M_HELD: begin
        if (ack) begin
          n.mode = M_DONE; n.valid = 1'b0; n.addr = '0;
        end else if (!c.pen) begin
          n.mode = M_WAIT; n.run = 0; n.valid = 1'b0; n.addr = '0;
        end else if (c.age == TIMEOUT_CYCLES - 1) begin
          n.mode = M_DONE; n.err = 1'b1; n.valid = 1'b0; n.addr = '0;
        end else begin
          n.age = c.age + 1;
        end
      end
      default: begin
        if (!c.pen) begin
          n.mode = M_WAIT; n.run = 0;
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge clk) m <= step(m, Reset, EN_in, {A2_in, A1_in, A0_in}, Ack_in);

  function automatic logic [12:0] expv(model_t c);
    logic [7:0] y;
    y = c.valid ? (8'b1 << c.addr) : 8'h00;
    return {c.valid, c.err, c.addr, y};
  endfunction

  logic [12:0] obs;
  assign obs = {Valid_out, Err_out, Addr_out, Y_out};

  task automatic tick(input logic en, input logic [2:0] a, input logic ack);
    EN_in = en;
    {A2_in, A1_in, A0_in} = a;
    Ack_in = ack;
    @(negedge clk);
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (2) begin
      tick(1'($urandom), 3'($urandom), 1'($urandom));
      checks++;
      if (obs !== 13'h0) begin
        failures++; $display("FAIL reset_outputs got=%h exp=%h", obs, 13'h0);
      end
    end
    Reset = 1'b0;
    repeat (5) begin
      tick(1'b0, 3'($urandom), 1'b0);
      checks++;
      if (obs !== expv(m) || obs !== 13'h0) begin
        failures++; $display("FAIL idle_link got=%h exp=%h", obs, 13'h0);
      end
    end
  endtask

  task automatic test_single;
    for (int k = 1; k <= 6; k++) begin
      tick(1'b1, 3'd5, 1'b0);
      checks++;
      if (obs !== expv(m)) begin
        failures++; $display("FAIL single_model k=%0d got=%h exp=%h", k, obs, expv(m));
      end
      checks++;
      if (k < 6 && Valid_out !== 1'b0) begin
        failures++; $display("FAIL single_early k=%0d valid=%b exp=0", k, Valid_out);
      end else if (k == 6 && {Valid_out, Addr_out, Y_out} !== {1'b1, 3'd5, 8'h20}) begin
        failures++; $display("FAIL single_decode valid=%b addr=%0d y=%h exp=1/5/20", Valid_out, Addr_out, Y_out);
      end
    end
    repeat (2) begin
      tick(1'b1, 3'd5, 1'b0);
      checks++;
      if (Y_out !== 8'h20 || Valid_out !== 1'b1) begin
        failures++; $display("FAIL single_hold y=%h valid=%b exp=20/1", Y_out, Valid_out);
      end
    end
    tick(1'b1, 3'd5, 1'b1);
    checks++;
    if (obs !== 13'h0) begin
      failures++; $display("FAIL single_ack_clear got=%h exp=%h", obs, 13'h0);
    end
    repeat (10) begin
      tick(1'b1, 3'd5, 1'b0);
      checks++;
      if (Valid_out !== 1'b0 || obs !== expv(m)) begin
        failures++; $display("FAIL single_no_retrigger got=%h exp=%h", obs, 13'h0);
      end
    end
    repeat (3) tick(1'b0, 3'd0, 1'b0);
  endtask

  task automatic test_restart;
    logic seen08;
    seen08 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1, (k <= 2) ? 3'd3 : 3'd6, 1'b0);
      if (Y_out === 8'h08) seen08 = 1'b1;
      checks++;
      if (obs !== expv(m)) begin
        failures++; $display("FAIL restart_model k=%0d got=%h exp=%h", k, obs, expv(m));
      end
    end
    checks++;
    if (Y_out !== 8'h40 || Addr_out !== 3'd6) begin
      failures++; $display("FAIL restart_decode y=%h addr=%0d exp=40/6", Y_out, Addr_out);
    end
    checks++;
    if (seen08) begin
      failures++; $display("FAIL restart_stale_addr saw=08 exp=never");
    end
    tick(1'b1, 3'd6, 1'b1);
    repeat (3) tick(1'b0, 3'd0, 1'b0);
  endtask

  task automatic test_timeout;
    repeat (6) tick(1'b1, 3'd2, 1'b0);
    checks++;
    if (Y_out !== 8'h04 || Valid_out !== 1'b1) begin
      failures++; $display("FAIL timeout_decode y=%h exp=04", Y_out);
    end
    for (int j = 1; j <= TIMEOUT_CYCLES; j++) begin
      tick(1'b1, 3'd2, 1'b0);
      checks++;
      if (obs !== expv(m)) begin
        failures++; $display("FAIL timeout_model j=%0d got=%h exp=%h", j, obs, expv(m));
      end
    end
    checks++;
    if ({Err_out, Valid_out, Y_out} !== {1'b1, 1'b0, 8'h00}) begin
      failures++; $display("FAIL timeout_err err=%b valid=%b y=%h exp=1/0/00", Err_out, Valid_out, Y_out);
    end
    repeat (2) tick(1'b0, 3'd0, 1'b0);
    repeat (6) tick(1'b1, 3'd1, 1'b0);
    checks++;
    if ({Err_out, Valid_out, Y_out} !== {1'b1, 1'b1, 8'h02}) begin
      failures++; $display("FAIL timeout_sticky err=%b valid=%b y=%h exp=1/1/02", Err_out, Valid_out, Y_out);
    end
    tick(1'b1, 3'd1, 1'b1);
    repeat (3) tick(1'b0, 3'd0, 1'b0);
  endtask

  task automatic test_abort;
    logic [2:0] a, b;
    a = 3'($urandom);
    b = 3'($urandom);
    Reset = 1'b1;
    tick(1'b0, 3'd0, 1'b0);
    Reset = 1'b0;
    repeat (6) tick(1'b1, a, 1'b0);
    checks++;
    if (Y_out !== (8'b1 << a) || Valid_out !== 1'b1) begin
      failures++; $display("FAIL abort_decode y=%h exp=%h", Y_out, 8'b1 << a);
    end
    tick(1'b0, a, 1'b0);
    tick(1'b0, a, 1'b1);
    checks++;
    if ({Valid_out, Err_out, Y_out} !== 10'h0) begin
      failures++; $display("FAIL abort_ack_and_drop got=%h exp=000", {Valid_out, Err_out, Y_out});
    end
    tick(1'b0, 3'd0, 1'b0);
    repeat (6) tick(1'b1, b, 1'b0);
    checks++;
    if (Y_out !== (8'b1 << b) || obs !== expv(m)) begin
      failures++; $display("FAIL abort_redecode y=%h exp=%h", Y_out, 8'b1 << b);
    end
    tick(1'b0, b, 1'b0);
    tick(1'b0, b, 1'b0);
    checks++;
    if ({Valid_out, Err_out, Y_out} !== 10'h0 || obs !== expv(m)) begin
      failures++; $display("FAIL abort_drop got=%h exp=000", {Valid_out, Err_out, Y_out});
    end
    repeat (2) tick(1'b0, 3'd0, 1'b0);
  endtask

  task automatic test_reset_mid;
    logic [2:0] c;
    c = 3'($urandom);
    repeat (6) tick(1'b1, 3'd7, 1'b0);
    checks++;
    if (Y_out !== 8'h80 || Addr_out !== 3'd7) begin
      failures++; $display("FAIL midreset_decode y=%h exp=80", Y_out);
    end
    Reset = 1'b1;
    tick(1'b1, 3'd7, 1'b0);
    Reset = 1'b0;
    checks++;
    if (obs !== 13'h0) begin
      failures++; $display("FAIL midreset_clear got=%h exp=%h", obs, 13'h0);
    end
    repeat (2) tick(1'b0, 3'd0, 1'b0);
    repeat (6) tick(1'b1, c, 1'b0);
    checks++;
    if ({Valid_out, Addr_out, Y_out} !== {1'b1, c, 8'b1 << c}) begin
      failures++; $display("FAIL midreset_redecode addr=%0d y=%h exp=%0d", Addr_out, Y_out, c);
    end
    tick(1'b1, c, 1'b1);
    repeat (2) tick(1'b0, 3'd0, 1'b0);
  endtask

  task automatic test_random;
    logic       en;
    logic [2:0] a;
    en = 1'b0;
    a  = 3'd0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) en = ~en;
      if ($urandom_range(0, 7) == 0) a = 3'($urandom);
      Reset = ($urandom_range(0, 149) == 0);
      tick(en, a, ($urandom_range(0, 5) == 0));
      Reset = 1'b0;
      checks++;
      if (obs !== expv(m)) begin
        failures++; $display("FAIL random_model i=%0d got=%h exp=%h", i, obs, expv(m));
      end
      checks++;
      if (!$onehot0(Y_out) || Valid_out !== (|Y_out)) begin
        failures++; $display("FAIL random_onehot i=%0d y=%h valid=%b", i, Y_out, Valid_out);
      end
    end
  endtask

  initial begin
    Reset  = 1'b1;
    EN_in  = 1'b0;
    A2_in  = 1'b0;
    A1_in  = 1'b0;
    A0_in  = 1'b0;
    Ack_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_restart();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
